wave_seq_engine: RTL and testbench
==================================

// Module: wave_seq_engine
// PURPOSE
//   Parametrised single-channel waveform sequencer: runs a small stored program
//   (opcode + param per slot) that drives one DAC code.
//   Successor to the fixed 4-slot triangle generator; adds run-time program
//   load, GOTO/HALT, rate enable, start/stop control and configurable widths.
//   Instantiated once per DAC axis (X/Y) in the image generator.
// PARAMETERS
//   DAC_W   8  DAC code width
//   PARAM_W 8  per-slot parameter width (PARAM_W >= DAC_W and >= PTR_W)
//   DEPTH   8  program slots (power of 2, >= 2)
//   PTR_W   $clog2(DEPTH)  program counter width (derived)
// PORTS
//   clk         in   1        clock
//   reset       in   1        synchronous, active-high reset
//   prog_we     in   1        program write strobe
//   prog_addr   in   PTR_W    slot to write
//   prog_op     in   3        opcode to write
//   prog_param  in   PARAM_W  param to write
//   start       in   1        pulse: run from slot 0
//   stop        in   1        pulse: abort to IDLE
//   step_en     in   1        rate strobe; one program step per cycle with step_en=1
//   dac_out     out  DAC_W    DAC code
//   busy        out  1        state == RUN
//   halted      out  1        state == DONE
//   pc          out  PTR_W    current slot
// BEHAVIOUR
//   Opcodes: NOP=0 LINE=1 INCR=2 DCRE=3 JUMP=4 GOTO=5 HALT=7; 6 executes as NOP.
//   Reset: dac_out=0, pc=0, step cnt=0, state IDLE, busy=0, halted=0,
//     every slot = {HALT,0}.
//   Program write: when prog_we=1 and state != RUN, slot[prog_addr] updates at the clock edge.
//     Writes during RUN are dropped.
//   States: IDLE -start-> RUN; RUN -HALT-> DONE; DONE -start-> RUN;
//     RUN/DONE -stop-> IDLE.
//     stop beats start in the same cycle. start during RUN is ignored.
//   On start: pc=0, cnt=0. dac_out keeps its value.
//   In RUN, slot[pc] is decoded combinationally. Nothing advances when step_en=0.
//   With step_en=1, per step:
//     NOP   pc+1
//     JUMP  dac=param[DAC_W-1:0]; pc+1
//     LINE  hold dac; cnt+1
//     INCR  dac+1; cnt+1
//     DCRE  dac-1; cnt+1
//       LINE/INCR/DCRE: when cnt+1 >= max(param,1), set pc+1 and cnt=0.
//       So N steps, and param 0 behaves as 1.
//     GOTO  pc=param[PTR_W-1:0]; cnt=0
//     HALT  state DONE; pc, dac held
//   pc increments wrap DEPTH-1 -> 0.
//   Ramps wrap modulo 2^DAC_W (255+1=0, 0-1=255) unless WAVE_SEQ_SAT_EN is set.
//   dac_out is registered; the new value is visible the cycle after the step.
//   stop/reset mid-ramp: cnt=0; dac_out held on stop, 0 on reset.
// CONFIGURATION
//   `WAVE_SEQ_SAT_EN defined: INCR clamps at 2^DAC_W-1 and DCRE clamps at 0.
//     The step count still runs to completion.
//   Not defined: modulo wrap as above.
// STRUCTURE
//   Package wave_seq_pkg: opcode localparams (OP_NOP..OP_HALT), OP_W=3,
//     state encodings (ST_IDLE, ST_RUN, ST_DONE).
//   Sub-module wave_seq_prog_mem: DEPTH x (3+PARAM_W) flop array with
//     synchronous write, async read, and reset to HALT.
//   The engine FSM, counter and DAC register stay in wave_seq_engine.
// TESTING
//   1 Reset, then start with step_en=1 -> halted=1 two cycles later;
//     dac_out=0; busy never drops mid-HALT.
//   2 Program {JUMP 10, INCR 100, DCRE 90, HALT}, start -> dac 10, ramps to 110,
//     back to 20, halted=1; ramp steps exactly 100 and 90 cycles.
//   3 Program {JUMP 250, INCR 10, GOTO 0} ->
//     without SAT: dac 251..255,0..4 repeating.
//     With WAVE_SEQ_SAT_EN: clamps at 255, then loops from 250.
//   4 step_en toggling 1-in-4 on {LINE 3, HALT} -> pc advances after
//     exactly 3 strobes (12 clocks).
//   5 stop mid-INCR at dac=37 -> IDLE, dac stays 37, busy=0.
//     stop+start in the same cycle -> IDLE.
//   6 prog_we during RUN to the current slot -> no effect.
//     Same write in IDLE -> slot read back by execution.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared opcode and FSM state definitions for the waveform sequencer.
// Optional feature macro used by the engine: WAVE_SEQ_SAT_EN (ramp saturation).
package wave_seq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_LINE = 3'd1;
  localparam logic [OP_W-1:0] OP_INCR = 3'd2;
  localparam logic [OP_W-1:0] OP_DCRE = 3'd3;
  localparam logic [OP_W-1:0] OP_JUMP = 3'd4;
  localparam logic [OP_W-1:0] OP_GOTO = 3'd5;
  localparam logic [OP_W-1:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wave_seq_prog_mem.sv
// Program store: DEPTH slots of {opcode, param}, synchronous write, async read.
// Every slot resets to {HALT, 0} so an unloaded program stops immediately.
module wave_seq_prog_mem
  import wave_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PARAM_W = 8,
  parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [OP_W-1:0]    wop,
  input  logic [PARAM_W-1:0] wparam,
  input  logic [PTR_W-1:0]   raddr,
  output logic [OP_W-1:0]    rop,
  output logic [PARAM_W-1:0] rparam
);

  logic [OP_W-1:0]    op_q  [DEPTH];
  logic [PARAM_W-1:0] par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]  <= OP_HALT;
        par_q[i] <= '0;
      end
    end else if (we) begin
      op_q[waddr]  <= wop;
      par_q[waddr] <= wparam;
    end
  end

  assign rop    = op_q[raddr];
  assign rparam = par_q[raddr];

endmodule

// File: rtl/wave_seq_engine.sv
// Single-channel waveform sequencer: executes the stored program and drives dac_out.
// Define WAVE_SEQ_SAT_EN to clamp INCR/DCRE ramps instead of wrapping.
module wave_seq_engine
  import wave_seq_pkg::*;
#(
  parameter int unsigned DAC_W   = 8,
  parameter int unsigned PARAM_W = 8,
  parameter int unsigned DEPTH   = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PTR_W-1:0]   prog_addr,
  input  logic [OP_W-1:0]    prog_op,
  input  logic [PARAM_W-1:0] prog_param,
  input  logic               start,
  input  logic               stop,
  input  logic               step_en,
  output logic [DAC_W-1:0]   dac_out,
  output logic               busy,
  output logic               halted,
  output logic [PTR_W-1:0]   pc
);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   pc_q, pc_d;
  logic [PARAM_W-1:0] cnt_q, cnt_d;
  logic [DAC_W-1:0]   dac_q, dac_d;

  logic [OP_W-1:0]    cur_op;
  logic [PARAM_W-1:0] cur_param;
  logic               mem_we;

  logic [PARAM_W:0]   cnt_inc;
  logic [PARAM_W:0]   run_len;
  logic               seg_done;
  logic [PTR_W-1:0]   pc_inc;
  logic [DAC_W-1:0]   dac_up;
  logic [DAC_W-1:0]   dac_dn;

  assign mem_we = prog_we && (state_q != ST_RUN);

  wave_seq_prog_mem #(
    .DEPTH   (DEPTH),
    .PARAM_W (PARAM_W),
    .PTR_W   (PTR_W)
  ) u_prog_mem (
    .clk    (clk),
    .reset  (reset),
    .we     (mem_we),
    .waddr  (prog_addr),
    .wop    (prog_op),
    .wparam (prog_param),
    .raddr  (pc_q),
    .rop    (cur_op),
    .rparam (cur_param)
  );

  // A zero-length segment runs one step, so the run length floors at 1.
  assign cnt_inc  = {1'b0, cnt_q} + (PARAM_W+1)'(1);
  assign run_len  = (cur_param == '0) ? (PARAM_W+1)'(1) : {1'b0, cur_param};
  assign seg_done = (cnt_inc >= run_len);
  assign pc_inc   = pc_q + PTR_W'(1);

`ifdef WAVE_SEQ_SAT_EN
  assign dac_up = (dac_q == '1) ? dac_q : dac_q + DAC_W'(1);
  assign dac_dn = (dac_q == '0) ? dac_q : dac_q - DAC_W'(1);
`else
  assign dac_up = dac_q + DAC_W'(1);
  assign dac_dn = dac_q - DAC_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      pc_d    = '0;
      cnt_d   = '0;
    end else if ((state_q == ST_RUN) && step_en) begin
      case (cur_op)
        OP_LINE, OP_INCR, OP_DCRE: begin
          if (cur_op == OP_INCR) dac_d = dac_up;
          if (cur_op == OP_DCRE) dac_d = dac_dn;
          if (seg_done) begin
            pc_d  = pc_inc;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc[PARAM_W-1:0];
          end
        end
        OP_JUMP: begin
          dac_d = cur_param[DAC_W-1:0];
          pc_d  = pc_inc;
        end
        OP_GOTO: begin
          pc_d  = cur_param[PTR_W-1:0];
          cnt_d = '0;
        end
        OP_HALT: state_d = ST_DONE;
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      dac_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      dac_q   <= dac_d;
    end
  end

  assign dac_out = dac_q;
  assign pc      = pc_q;
  assign busy    = (state_q == ST_RUN);
  assign halted  = (state_q == ST_DONE);

endmodule

// File: tb/tb_wave_seq_engine.sv
// Self-checking bench for wave_seq_engine: directed scenarios plus random traffic
// compared every cycle against an integer-arithmetic program interpreter.
module tb_wave_seq_engine;

  localparam int DAC_W   = 8;
  localparam int PARAM_W = 8;
  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;
  localparam int DAC_MOD = 1 << DAC_W;

  logic               clk = 1'b0;
  logic               reset, prog_we, start, stop, step_en;
  logic [PTR_W-1:0]   prog_addr;
  logic [2:0]         prog_op;
  logic [PARAM_W-1:0] prog_param;
  logic [DAC_W-1:0]   dac_out;
  logic               busy, halted;
  logic [PTR_W-1:0]   pc;

  int checks = 0;
  int errors = 0;

  // Reference interpreter state (0 = idle, 1 = running, 2 = done)
  int m_op [DEPTH];
  int m_par[DEPTH];
  int m_state, m_pc, m_cnt, m_dac;

  wave_seq_engine #(
    .DAC_W   (DAC_W),
    .PARAM_W (PARAM_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_op    (prog_op),
    .prog_param (prog_param),
    .start      (start),
    .stop       (stop),
    .step_en    (step_en),
    .dac_out    (dac_out),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_exec();
    int op, p, len;
    op  = m_op[m_pc];
    p   = m_par[m_pc];
    len = (p == 0) ? 1 : p;
    case (op)
      1, 2, 3: begin
`ifdef WAVE_SEQ_SAT_EN
        if (op == 2 && m_dac < DAC_MOD - 1) m_dac = m_dac + 1;
        if (op == 3 && m_dac > 0)           m_dac = m_dac - 1;
`else
        if (op == 2) m_dac = (m_dac + 1) % DAC_MOD;
        if (op == 3) m_dac = (m_dac + DAC_MOD - 1) % DAC_MOD;
`endif
        m_cnt++;
        if (m_cnt >= len) begin
          m_cnt = 0;
          m_pc  = (m_pc + 1) % DEPTH;
        end
      end
      4: begin
        m_dac = p % DAC_MOD;
        m_pc  = (m_pc + 1) % DEPTH;
      end
      5: begin
        m_pc  = p % DEPTH;
        m_cnt = 0;
      end
      7: m_state = 2;
      default: m_pc = (m_pc + 1) % DEPTH;
    endcase
  endtask

  task automatic model_step();
    if (reset) begin
      m_state = 0; m_pc = 0; m_cnt = 0; m_dac = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_op[i]  = 7;
        m_par[i] = 0;
      end
    end else begin
      if (prog_we && m_state != 1) begin
        m_op[prog_addr]  = int'(prog_op);
        m_par[prog_addr] = int'(prog_param);
      end
      if (stop) begin
        m_state = 0;
        m_cnt   = 0;
      end else if (start && m_state != 1) begin
        m_state = 1;
        m_pc    = 0;
        m_cnt   = 0;
      end else if (m_state == 1 && step_en) begin
        model_exec();
      end
    end
  endtask

  // One clock: model follows the inputs seen at the edge, outputs compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("dac", dac_out, m_dac);
    check("pc", pc, m_pc);
    check("busy", busy, m_state == 1);
    check("halted", halted, m_state == 2);
  endtask

  task automatic load(input int addr, input int op, input int param);
    prog_we    = 1'b1;
    prog_addr  = PTR_W'(addr);
    prog_op    = 3'(op);
    prog_param = PARAM_W'(param);
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    int n_up, n_dn, maxd, clocks, first_top;
    bit seen;

    reset = 1'b1; prog_we = 1'b0; start = 1'b0; stop = 1'b0; step_en = 1'b0;
    prog_addr = '0; prog_op = '0; prog_param = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_dac", dac_out, 0);
    check("rst_busy", busy, 0);

    // 1: empty program halts two clocks after start
    step_en = 1'b1;
    pulse_start();
    check("t1_busy", busy, 1);
    tick();
    check("t1_halted", halted, 1);
    check("t1_dac", dac_out, 0);

    // 2: jump/ramp up/ramp down/halt
    load(0, 4, 10); load(1, 2, 100); load(2, 3, 90); load(3, 7, 0);
    step_en = 1'b1;
    pulse_start();
    n_up = 0; n_dn = 0; maxd = 0;
    for (int k = 0; k < 400 && !halted; k++) begin
      tick();
      if (pc == 1) n_up++;
      if (pc == 2) n_dn++;
      if (int'(dac_out) > maxd) maxd = int'(dac_out);
    end
    check("t2_halted", halted, 1);
    check("t2_up_steps", n_up, 100);
    check("t2_dn_steps", n_dn, 90);
    check("t2_peak", maxd, 110);
    check("t2_final", dac_out, 20);

    // 3: ramp across the top of the DAC range
    load(0, 4, 250); load(1, 2, 10); load(2, 5, 0);
    pulse_start();
    seen = 1'b0; first_top = -1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (pc == 2 && !seen) begin
        seen = 1'b1;
        first_top = int'(dac_out);
      end
    end
`ifdef WAVE_SEQ_SAT_EN
    check("t3_ramp_end", first_top, 255);
`else
    check("t3_ramp_end", first_top, 4);
`endif
    pulse_stop();

    // 4: rate strobe 1-in-4 on a 3-step LINE
    load(0, 1, 3); load(1, 7, 0);
    step_en = 1'b0;
    pulse_start();
    clocks = 0;
    for (int k = 0; k < 50; k++) begin
      step_en = ((k % 4) == 3);
      tick();
      clocks++;
      if (pc == 1) break;
    end
    check("t4_clocks", clocks, 12);
    pulse_stop();

    // 5: stop mid-ramp holds the DAC code
    load(0, 4, 0); load(1, 2, 200);
    step_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 100 && dac_out != 37; k++) tick();
    pulse_stop();
    check("t5_dac", dac_out, 37);
    check("t5_busy", busy, 0);
    tick(); tick();
    check("t5_dac_hold", dac_out, 37);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_both_busy", busy, 0);
    check("t5_both_halted", halted, 0);

    // 6: program writes are dropped while running
    load(0, 4, 5); load(1, 1, 50); load(2, 7, 0);
    pulse_start();
    for (int k = 0; k < 10 && pc != 1; k++) tick();
    load(1, 4, 99);
    for (int k = 0; k < 200 && !halted; k++) tick();
    check("t6_run_halted", halted, 1);
    check("t6_run_dac", dac_out, 5);
    load(1, 4, 99);
    pulse_start();
    for (int k = 0; k < 20 && !halted; k++) tick();
    check("t6_idle_halted", halted, 1);
    check("t6_idle_dac", dac_out, 99);

    // Random traffic against the interpreter
    for (int k = 0; k < 4000; k++) begin
      int op;
      op         = int'($urandom_range(0, 7));
      prog_we    = ($urandom_range(0, 3) == 0);
      prog_addr  = PTR_W'($urandom_range(0, DEPTH - 1));
      prog_op    = 3'(op);
      prog_param = (op >= 1 && op <= 3) ? PARAM_W'($urandom_range(0, 4))
                                        : PARAM_W'($urandom);
      start      = ($urandom_range(0, 19) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      step_en    = ($urandom_range(0, 1) == 1);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
